multicycle_control: RTL and testbench
=====================================

# multicycle_control

Parametrised FSM control unit for the multi-cycle datapath, successor to the single-cycle combinational decoder. It decodes the same 15-instruction subset (add, addi, addu, sub, subu, and, or, sll, lw, sw, beq, bne, bgtz, slt, sltu). It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB/BRANCH over a shared memory with a ready handshake. It adds illegal-opcode trapping, a memory-timeout trap and a retired-instruction counter.

## Interface
Parameters:
- MEM_TIMEOUT, 16: consecutive not-ready cycles allowed per memory access; 0 disables the timeout.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high.
- op  in  6  IR[31:26]; valid from DECODE onward.
- funct  in  6  IR[5:0].
- equal  in  1  ALU A==B flag, combinational from the current ALU operation.
- sign  in  1  ALU result bit 31.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory access request.
- mem_we  out  1  write when mem_req=1.
- iord  out  1  memory address select: 0=PC, 1=ALUOut register.
- ir_write  out  1  load IR from memory data.
- pc_write  out  1  PC <= ALU result (PC+4).
- pc_branch  out  1  PC <= ALUOut register (branch target).
- reg_wr  out  1  register file write.
- reg_dst  out  1  write-register select: 1=Rd (R-type), 0=Rt.
- mem_to_reg  out  1  busW select: 1=MDR, 0=ALUOut.
- ext_op  out  1  sign-extend Imm16.
- alu_src_a  out  1  0=PC, 1=busA.
- alu_src_b  out  2  0=busB, 1=constant 4, 2=Imm32, 3=Imm32<<2.
- alu_ctr  out  3  0=and, 1=or, 2=add, 3=slt, 4=addu, 5=sll, 6=sub, 7=sltu.
- illegal  out  1  sticky: undecodable instruction.
- timeout_err  out  1  sticky: memory timeout.
- retired  out  CNT_W  completed instructions, wraps modulo 2^CNT_W.
- state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, BRANCH=5, HALT=6.

## Operation
- Legal opcodes:
  - R-type 000000
  - addi 001000, lw 100011, sw 101011
  - beq 000100, bne 000101, bgtz 000111
- Legal R-type functs:
  - 100000 add, 100001 addu, 100010 sub, 100011 subu
  - 100100 and, 100101 or, 000000 sll
  - 101010 slt, 101011 sltu
- Anything else is illegal.
- Outputs not listed for a state are 0.
- FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=1, alu_ctr=2.
  - mem_ready=1: ir_write=1, pc_write=1 (combinational on mem_ready); next state DECODE.
  - Otherwise stay in FETCH.
- DECODE: alu_src_a=0, alu_src_b=3, ext_op=1, alu_ctr=2; the datapath latches the branch target into ALUOut.
  - Next state: illegal -> HALT and set illegal; branch -> BRANCH; otherwise EXEC.
- EXEC:
  - R-type: alu_src_a=1, alu_src_b=0, alu_ctr per funct (add 2, addu 4, sub/subu 6, and 0, or 1, sll 5, slt 3, sltu 7).
  - addi/lw/sw: alu_src_a=1, alu_src_b=2, ext_op=1, alu_ctr=2.
  - Next state: lw/sw -> MEM; otherwise WB.
- MEM: mem_req=1, iord=1, mem_we=(op==sw).
  - On mem_ready: lw -> WB; sw -> FETCH and retire.
  - Otherwise stay in MEM.
- WB: reg_wr=1, reg_dst=R-type, mem_to_reg=lw; next state FETCH and retire.
- BRANCH: alu_src_a=1, alu_src_b=0, alu_ctr=6.
  - pc_branch = (beq & equal) | (bne & ~equal) | (bgtz & ~equal & ~sign); combinational.
  - Next state FETCH and retire, whether or not the branch is taken.
- HALT: all strobes 0; state is held until reset.
- Retire: retired += 1 on the exit edge.
- Timeout: a wait counter clears on entry to FETCH or MEM and increments each cycle with mem_req=1 & mem_ready=0.
  - When MEM_TIMEOUT≠0 and the counter reaches MEM_TIMEOUT-1 with mem_ready=0, the FSM goes to HALT and sets timeout_err.
  - mem_ready=1 in that same cycle wins: the access completes normally.

## Timing
- Reset is sampled on the clock edge. The next state is FETCH; retired, the wait counter, illegal and timeout_err all become 0.
- While reset=1, every strobe output is forced to 0.
- The first mem_req appears in the first cycle after reset is deasserted.
- Cycles per instruction with zero wait states:
  - R-type/addi: 4
  - lw: 5
  - sw: 4
  - branch: 3
- Each memory wait cycle adds 1.
- ir_write, pc_write and pc_branch are Mealy outputs. All other outputs decode from state and the latched op/funct only.
- Simultaneous mem_ready and timeout expiry: the access completes; no trap.
- Reset asserted mid-instruction aborts it. No retire increment; no strobes in that cycle.

## Test plan
- Reset, then R-type add with mem_ready=1 always -> states 0,1,2,4,0. reg_wr=1 only in WB with reg_dst=1 and alu_ctr=2 in EXEC. retired=1 after 4 cycles.
- lw with mem_ready held low 3 cycles in MEM, MEM_TIMEOUT=16 -> stays in MEM 4 cycles with iord=1 and mem_we=0. Then WB with mem_to_reg=1. 8 cycles total; retired increments by 1.
- beq with equal=1 -> pc_branch=1 in BRANCH. bne with equal=1 -> pc_branch=0. bgtz with equal=0, sign=0 -> pc_branch=1. bgtz with sign=1 -> 0. Each takes 3 cycles.
- op=6'b111111 -> DECODE then HALT, illegal=1. Outputs stay 0 for 20 cycles. reset clears it and returns to FETCH.
- MEM_TIMEOUT=4 with mem_ready stuck at 0 in FETCH -> HALT after 4 FETCH cycles, timeout_err=1. The same test with mem_ready=1 on the 4th cycle -> DECODE, no error.
- CNT_W=4: run 17 sw instructions -> retired wraps to 1. Asserting reset in EXEC -> retired=0 and state=FETCH next cycle.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Memory handshake between the multi-cycle controller and the shared memory.
interface multicycle_control_if;
    logic mem_req;
    logic mem_we;
    logic iord;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output iord,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  iord,
        output mem_ready
    );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle FSM controller for the 15-instruction MIPS subset.
// Sequences FETCH/DECODE/EXEC/MEM/WB/BRANCH, traps illegal opcodes and
// memory timeouts into HALT, and counts retired instructions.
module multicycle_control #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    multicycle_control_if.master  bus,
    input  logic [5:0]            op,
    input  logic [5:0]            funct,
    input  logic                  equal,
    input  logic                  sign,
    output logic                  ir_write,
    output logic                  pc_write,
    output logic                  pc_branch,
    output logic                  reg_wr,
    output logic                  reg_dst,
    output logic                  mem_to_reg,
    output logic                  ext_op,
    output logic                  alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [2:0]            alu_ctr,
    output logic                  illegal,
    output logic                  timeout_err,
    output logic [CNT_W-1:0]      retired,
    output logic [2:0]            state
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        BRANCH = 3'd5,
        HALT   = 3'd6
    } state_t;

    // Moore control word, registered alongside the state it belongs to.
    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       reg_wr;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       ext_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_ctr;
    } ctl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_BGTZ  = 6'b000111;

    // Wait counter only has to reach MEM_TIMEOUT-1.
    localparam int              WAIT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam bit              TO_EN     = (MEM_TIMEOUT != 0);

    function automatic logic funct_legal(input logic [5:0] f);
        case (f)
            6'b100000, 6'b100001, 6'b100010, 6'b100011,
            6'b100100, 6'b100101, 6'b000000,
            6'b101010, 6'b101011: return 1'b1;
            default:              return 1'b0;
        endcase
    endfunction

    function automatic logic instr_legal(input logic [5:0] o, input logic [5:0] f);
        case (o)
            OP_RTYPE:                               return funct_legal(f);
            OP_ADDI, OP_LW, OP_SW,
            OP_BEQ, OP_BNE, OP_BGTZ:                return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] rtype_alu(input logic [5:0] f);
        case (f)
            6'b100000: return 3'd2;
            6'b100001: return 3'd4;
            6'b100010,
            6'b100011: return 3'd6;
            6'b100100: return 3'd0;
            6'b100101: return 3'd1;
            6'b000000: return 3'd5;
            6'b101010: return 3'd3;
            6'b101011: return 3'd7;
            default:   return 3'd0;
        endcase
    endfunction

    function automatic ctl_t decode_ctl(input state_t s, input logic [5:0] o, input logic [5:0] f);
        ctl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.mem_req   = 1'b1;
                c.alu_src_b = 2'd1;
                c.alu_ctr   = 3'd2;
            end
            DECODE: begin
                c.alu_src_b = 2'd3;
                c.ext_op    = 1'b1;
                c.alu_ctr   = 3'd2;
            end
            EXEC: begin
                c.alu_src_a = 1'b1;
                if (o == OP_RTYPE) begin
                    c.alu_src_b = 2'd0;
                    c.alu_ctr   = rtype_alu(f);
                end else begin
                    c.alu_src_b = 2'd2;
                    c.ext_op    = 1'b1;
                    c.alu_ctr   = 3'd2;
                end
            end
            MEM: begin
                c.mem_req = 1'b1;
                c.iord    = 1'b1;
                c.mem_we  = (o == OP_SW);
            end
            WB: begin
                c.reg_wr     = 1'b1;
                c.reg_dst    = (o == OP_RTYPE);
                c.mem_to_reg = (o == OP_LW);
            end
            BRANCH: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'd0;
                c.alu_ctr   = 3'd6;
            end
            default: ;
        endcase
        return c;
    endfunction

    state_t             state_q;
    state_t             nxt;
    ctl_t               ctl_q;
    logic [5:0]         op_q;
    logic [5:0]         funct_q;
    logic [5:0]         op_nxt;
    logic [5:0]         funct_nxt;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [CNT_W-1:0]   retired_q;
    logic               illegal_q;
    logic               timeout_q;
    logic               expire;
    logic               taken;
    logic               retire;

    assign expire = TO_EN && (wait_cnt == WAIT_LAST) && !bus.mem_ready;

    // op/funct become valid in DECODE and are latched for the later states.
    assign op_nxt    = (state_q == DECODE) ? op    : op_q;
    assign funct_nxt = (state_q == DECODE) ? funct : funct_q;

    assign taken = ((op_q == OP_BEQ)  &  equal) |
                   ((op_q == OP_BNE)  & ~equal) |
                   ((op_q == OP_BGTZ) & ~equal & ~sign);

    // Next-state selection; every exit back to FETCH is a retirement.
    always_comb begin
        nxt = state_q;
        case (state_q)
            FETCH: begin
                if (bus.mem_ready)  nxt = DECODE;
                else if (expire)    nxt = HALT;
            end
            DECODE: begin
                if (!instr_legal(op, funct))                        nxt = HALT;
                else if (op == OP_BEQ || op == OP_BNE || op == OP_BGTZ) nxt = BRANCH;
                else                                                nxt = EXEC;
            end
            EXEC:    nxt = (op_q == OP_LW || op_q == OP_SW) ? MEM : WB;
            MEM: begin
                if (bus.mem_ready)  nxt = (op_q == OP_SW) ? FETCH : WB;
                else if (expire)    nxt = HALT;
            end
            WB:      nxt = FETCH;
            BRANCH:  nxt = FETCH;
            default: nxt = HALT;
        endcase
        retire = (nxt == FETCH) && (state_q != FETCH);
    end

    // State, registered Moore outputs, wait counter, traps and retire count.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH;
            ctl_q     <= decode_ctl(FETCH, 6'd0, 6'd0);
            op_q      <= '0;
            funct_q   <= '0;
            wait_cnt  <= '0;
            retired_q <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q <= nxt;
            ctl_q   <= decode_ctl(nxt, op_nxt, funct_nxt);
            op_q    <= op_nxt;
            funct_q <= funct_nxt;
            if ((nxt == FETCH || nxt == MEM) && nxt != state_q)
                wait_cnt <= '0;
            else if (ctl_q.mem_req && !bus.mem_ready)
                wait_cnt <= wait_cnt + 1'b1;
            if (retire)
                retired_q <= retired_q + 1'b1;
            if (state_q == DECODE && !instr_legal(op, funct))
                illegal_q <= 1'b1;
            if ((state_q == FETCH || state_q == MEM) && expire)
                timeout_q <= 1'b1;
        end
    end

    // Strobes are silenced during the reset cycle; Mealy strobes follow inputs.
    assign bus.mem_req = ctl_q.mem_req & ~reset;
    assign bus.mem_we  = ctl_q.mem_we  & ~reset;
    assign bus.iord    = ctl_q.iord    & ~reset;
    assign reg_wr      = ctl_q.reg_wr     & ~reset;
    assign reg_dst     = ctl_q.reg_dst    & ~reset;
    assign mem_to_reg  = ctl_q.mem_to_reg & ~reset;
    assign ext_op      = ctl_q.ext_op     & ~reset;
    assign alu_src_a   = ctl_q.alu_src_a  & ~reset;
    assign alu_src_b   = reset ? 2'd0 : ctl_q.alu_src_b;
    assign alu_ctr     = reset ? 3'd0 : ctl_q.alu_ctr;
    assign ir_write    = (state_q == FETCH)  & bus.mem_ready & ~reset;
    assign pc_write    = (state_q == FETCH)  & bus.mem_ready & ~reset;
    assign pc_branch   = (state_q == BRANCH) & taken & ~reset;

    assign illegal     = illegal_q;
    assign timeout_err = timeout_q;
    assign retired     = retired_q;
    assign state       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomised scoreboard bench for multicycle_control (MEM_TIMEOUT=4, CNT_W=4).
module tb_multicycle_control;
    localparam int TO    = 4;
    localparam int CNT_W = 4;

    localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
                           S_MEM = 3'd3, S_WB = 3'd4, S_BRANCH = 3'd5, S_HALT = 3'd6;

    typedef struct packed {
        logic             rst;
        logic [2:0]       st;
        logic [15:0]      stb;
        logic             ill;
        logic             to;
        logic [CNT_W-1:0] ret;
    } cyc_t;

    logic clk = 1'b0;
    logic reset;
    logic [5:0] op, funct;
    logic equal, sign;
    logic ir_write, pc_write, pc_branch, reg_wr, reg_dst, mem_to_reg, ext_op, alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctr;
    logic illegal, timeout_err;
    logic [CNT_W-1:0] retired;
    logic [2:0] state;

    multicycle_control_if bus();

    multicycle_control #(.MEM_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .bus(bus), .op(op), .funct(funct),
        .equal(equal), .sign(sign), .ir_write(ir_write), .pc_write(pc_write),
        .pc_branch(pc_branch), .reg_wr(reg_wr), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .ext_op(ext_op), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_ctr(alu_ctr), .illegal(illegal),
        .timeout_err(timeout_err), .retired(retired), .state(state)
    );

    always #5 clk = ~clk;

    cyc_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc_no = 0;
    int   m_ret  = 0;
    bit   m_ill  = 1'b0;
    bit   m_to   = 1'b0;
    cyc_t mon_e;

    logic [5:0] rfn  [9] = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100,
                             6'b100101, 6'b000000, 6'b101010, 6'b101011};
    logic [5:0] iops [6] = '{6'b001000, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b000111};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%h want=%h", nm, cyc_no, act, want);
        end
    endtask

    // Strobe word: mem_req mem_we iord ir_write pc_write pc_branch reg_wr reg_dst mem_to_reg ext_op alu_src_a alu_src_b alu_ctr
    function automatic logic [15:0] mk(input logic mr, input logic we, input logic io,
                                       input logic irw, input logic pcw, input logic pcb,
                                       input logic rw, input logic rd, input logic m2r,
                                       input logic ext, input logic sa,
                                       input logic [1:0] sb, input logic [2:0] ctr);
        return {mr, we, io, irw, pcw, pcb, rw, rd, m2r, ext, sa, sb, ctr};
    endfunction

    // Instruction table: which class an (op, funct) pair belongs to and its ALU op.
    task automatic classify(input logic [5:0] o, input logic [5:0] f, output bit legal,
                            output bit is_r, output bit is_br, output bit is_lw,
                            output bit is_sw, output logic [2:0] ctr);
        legal = 1'b1; is_r = 1'b0; is_br = 1'b0; is_lw = 1'b0; is_sw = 1'b0; ctr = 3'd2;
        case (o)
            6'b000000: begin
                is_r = 1'b1;
                case (f)
                    6'b100000: ctr = 3'd2;
                    6'b100001: ctr = 3'd4;
                    6'b100010: ctr = 3'd6;
                    6'b100011: ctr = 3'd6;
                    6'b100100: ctr = 3'd0;
                    6'b100101: ctr = 3'd1;
                    6'b000000: ctr = 3'd5;
                    6'b101010: ctr = 3'd3;
                    6'b101011: ctr = 3'd7;
                    default:   legal = 1'b0;
                endcase
            end
            6'b001000: ;
            6'b100011: is_lw = 1'b1;
            6'b101011: is_sw = 1'b1;
            6'b000100, 6'b000101, 6'b000111: is_br = 1'b1;
            default: legal = 1'b0;
        endcase
    endtask

    // One clock cycle: drive inputs, queue the expected DUT response.
    task automatic emit(input logic [2:0] st, input logic [15:0] stb, input logic rdy,
                        input logic [5:0] o, input logic [5:0] f, input logic eq,
                        input logic sg, input int rst_at, inout int n, output bit ab);
        cyc_t c;
        c.rst = (n == rst_at);
        c.st  = st;
        c.stb = c.rst ? 16'd0 : stb;
        c.ill = m_ill;
        c.to  = m_to;
        c.ret = m_ret[CNT_W-1:0];
        @(posedge clk);
        #1;
        reset = c.rst; bus.mem_ready = rdy; op = o; funct = f; equal = eq; sign = sg;
        exp_q.push_back(c);
        ab = c.rst;
        if (c.rst) begin
            m_ret = 0; m_ill = 1'b0; m_to = 1'b0;
        end
        n++;
    endtask

    task automatic do_halt(input int hold, input int rst_at, inout int n);
        bit ab;
        for (int k = 0; k < hold; k++) begin
            emit(S_HALT, 16'd0, 1'($urandom), 6'($urandom), 6'($urandom), 1'($urandom),
                 1'($urandom), rst_at, n, ab);
            if (ab) return;
        end
        emit(S_HALT, 16'd0, 1'($urandom), 6'($urandom), 6'($urandom), 1'($urandom),
             1'($urandom), n, n, ab);
    endtask

    // Reference model of one instruction with wf/wm not-ready cycles on fetch/memory.
    task automatic do_instr(input logic [5:0] iop, input logic [5:0] ifn, input int wf,
                            input int wm, input logic b_eq, input logic b_sg,
                            input int rst_at, input int hold);
        int n; bit ab; bit legal, is_r, is_br, is_lw, is_sw; logic [2:0] ctr;
        logic rdy, pcb;
        n = 0;
        classify(iop, ifn, legal, is_r, is_br, is_lw, is_sw, ctr);
        for (int i = 0; i < 64; i++) begin
            rdy = (i >= wf);
            emit(S_FETCH, mk(1'b1, 1'b0, 1'b0, rdy, rdy, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 3'd2),
                 rdy, 6'($urandom), 6'($urandom), 1'($urandom), 1'($urandom), rst_at, n, ab);
            if (ab) return;
            if (rdy) break;
            if (i == TO - 1) begin
                m_to = 1'b1;
                do_halt(hold, rst_at, n);
                return;
            end
        end
        emit(S_DECODE, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 3'd2),
             1'($urandom), iop, ifn, 1'($urandom), 1'($urandom), rst_at, n, ab);
        if (ab) return;
        if (!legal) begin
            m_ill = 1'b1;
            do_halt(hold, rst_at, n);
            return;
        end
        if (is_br) begin
            case (iop)
                6'b000100: pcb = b_eq;
                6'b000101: pcb = ~b_eq;
                default:   pcb = ~b_eq & ~b_sg;
            endcase
            emit(S_BRANCH, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, pcb, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 3'd6),
                 1'($urandom), iop, ifn, b_eq, b_sg, rst_at, n, ab);
            if (ab) return;
            m_ret++;
            return;
        end
        if (is_r)
            emit(S_EXEC, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, ctr),
                 1'($urandom), iop, ifn, 1'($urandom), 1'($urandom), rst_at, n, ab);
        else
            emit(S_EXEC, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 3'd2),
                 1'($urandom), iop, ifn, 1'($urandom), 1'($urandom), rst_at, n, ab);
        if (ab) return;
        if (is_lw || is_sw) begin
            for (int i = 0; i < 64; i++) begin
                rdy = (i >= wm);
                emit(S_MEM, mk(1'b1, is_sw, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0),
                     rdy, iop, ifn, 1'($urandom), 1'($urandom), rst_at, n, ab);
                if (ab) return;
                if (rdy) begin
                    if (is_sw) begin
                        m_ret++;
                        return;
                    end
                    break;
                end
                if (i == TO - 1) begin
                    m_to = 1'b1;
                    do_halt(hold, rst_at, n);
                    return;
                end
            end
        end
        emit(S_WB, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, is_r, is_lw, 1'b0, 1'b0, 2'd0, 3'd0),
             1'($urandom), iop, ifn, 1'($urandom), 1'($urandom), rst_at, n, ab);
        if (ab) return;
        m_ret++;
    endtask

    // Monitor: compare every presented cycle against the queued expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            cyc_no++;
            chk("state", 32'(state), 32'(mon_e.st));
            chk("strobes", 32'({bus.mem_req, bus.mem_we, bus.iord, ir_write, pc_write, pc_branch,
                                reg_wr, reg_dst, mem_to_reg, ext_op, alu_src_a, alu_src_b, alu_ctr}),
                32'(mon_e.stb));
            chk("status", 32'({illegal, timeout_err, retired}),
                32'({mon_e.ill, mon_e.to, mon_e.ret}));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog cycle=%0d got=running want=finished", cyc_no);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r, wf, wm, ra;
        logic [5:0] ro, rf;
        reset = 1'b1; bus.mem_ready = 1'b0; op = '0; funct = '0; equal = 1'b0; sign = 1'b0;
        repeat (3) @(posedge clk);

        do_instr(6'b000000, 6'b100000, 0, 0, 1'b0, 1'b0, -1, 0);   // add
        do_instr(6'b100011, 6'd0, 0, 3, 1'b0, 1'b0, -1, 0);        // lw, 3 memory waits
        do_instr(6'b000100, 6'd0, 0, 0, 1'b1, 1'b0, -1, 0);        // beq taken
        do_instr(6'b000101, 6'd0, 0, 0, 1'b1, 1'b0, -1, 0);        // bne not taken
        do_instr(6'b000111, 6'd0, 0, 0, 1'b0, 1'b0, -1, 0);        // bgtz taken
        do_instr(6'b000111, 6'd0, 0, 0, 1'b0, 1'b1, -1, 0);        // bgtz negative
        do_instr(6'b111111, 6'd0, 0, 0, 1'b0, 1'b0, -1, 20);       // illegal opcode
        do_instr(6'b000000, 6'b100010, 4, 0, 1'b0, 1'b0, -1, 3);   // fetch timeout
        do_instr(6'b000000, 6'b100010, 3, 0, 1'b0, 1'b0, -1, 0);   // ready on last allowed cycle
        do_instr(6'b000000, 6'b100000, 0, 0, 1'b0, 1'b0, 2, 0);    // reset in EXEC
        for (int k = 0; k < 17; k++)
            do_instr(6'b101011, 6'd0, 0, 0, 1'b0, 1'b0, -1, 0);    // counter wrap
        do_instr(6'b101011, 6'd0, 0, 4, 1'b0, 1'b0, -1, 2);        // memory timeout

        for (int k = 0; k < 400; k++) begin
            r = $urandom_range(0, 19);
            if (r == 0) begin
                ro = 6'($urandom); rf = 6'($urandom);
            end else if (r < 10) begin
                ro = 6'd0; rf = rfn[$urandom_range(0, 8)];
            end else begin
                ro = iops[$urandom_range(0, 5)]; rf = 6'($urandom);
            end
            wf = ($urandom_range(0, 9) < 7) ? 0 : $urandom_range(1, 5);
            wm = ($urandom_range(0, 9) < 7) ? 0 : $urandom_range(1, 5);
            ra = ($urandom_range(0, 14) == 0) ? $urandom_range(0, 6) : -1;
            do_instr(ro, rf, wf, wm, 1'($urandom), 1'($urandom), ra, $urandom_range(1, 8));
        end

        repeat (2) @(posedge clk);
        chk("drain", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
